board_state: RTL and testbench
==============================

BOARD_STATE -- requirements
Module: board_state

Interface
- REQ-001: Parameter: none; all constants come from the shared package.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: move_valid  input  1  move request present.
- REQ-005: move_ready  output  1  block can accept a request.
- REQ-006: from_row, from_col  input  3 each  source square; (0,0) is top-left, (7,7) is bottom-right.
- REQ-007: to_row, to_col  input  3 each  destination square.
- REQ-008: mover_color  input  1  colour of the side moving; white=0, black=1.
- REQ-009: boardPos  output  [2:0] x [7:0][7:0]  board image.
  - Per-square encoding: bit0 occupied, bit1 colour (0 when empty), bit2 king.
- REQ-010: move_done  output  1  one-cycle pulse: move applied.
- REQ-011: move_err  output  1  one-cycle pulse: move rejected; board unchanged.
- REQ-012: captured  output  1  valid with move_done: destination was occupied.
- REQ-013: king_captured  output  1  sticky: a king was taken; game over.
- REQ-014: turn  output  1  colour expected to move next.

Function
- REQ-015: FSM states are IDLE, CHECK, APPLY, RESP and OVER.
- REQ-016: move_ready is 1 only in IDLE; a request is accepted on the cycle where move_valid and move_ready are both 1.
  - At acceptance, from_row, from_col, to_row, to_col and mover_color are registered.
  - These inputs are ignored in all other cycles.
- REQ-017: CHECK flags an error if any of the following holds:
  - source square is empty;
  - source colour differs from mover_color;
  - mover_color differs from turn;
  - source equals destination;
  - destination is occupied by mover_color.
- REQ-018: CHECK on error goes to RESP with move_err set; otherwise it goes to APPLY.
- REQ-019: APPLY writes the source code into the destination square and 3'b000 into the source square, in the same edge.
  - On that edge, captured is latched as the destination's pre-move bit0.
  - On that edge, turn toggles.
- REQ-020: APPLY sets king_captured if the destination's pre-move bit2 was 1.
- REQ-021: Latency, with acceptance in cycle N:
  - legal move: board updated and visible in N+3; move_done=1 in N+3;
  - illegal move: move_err=1 in N+2.
- REQ-022: move_done and move_err are never both 1; each lasts exactly one cycle.
- REQ-023: RESP returns to IDLE, or to OVER if king_captured is 1.
- REQ-024: OVER holds move_ready=0 and keeps the board frozen until reset.
- REQ-025: captured holds its value until the next move_done.
- REQ-026: boardPos is driven directly from registers, with no combinational path from the inputs.
- REQ-027: Legality of piece geometry (knight, rook, etc.) is not checked here; the downstream move-allow blocks own it.

Reset
- REQ-028: Asserting reset in any state, including mid-APPLY, forces the outputs below within the same cycle and aborts any in-flight move:
  - state=IDLE, turn=0, captured=0, king_captured=0, move_done=0, move_err=0;
  - move_ready=1 once reset deasserts.
- REQ-029: Board reset image:
  - rows 0-1: 3'b011;
  - square (0,4): 3'b111;
  - rows 6-7: 3'b001;
  - square (7,4): 3'b101;
  - rows 2-5: 3'b000.

Configuration
- REQ-030: With macro BOARD_TURN_CHECK_EN defined, the mover_color-vs-turn check in REQ-017 is active.
- REQ-031: Without BOARD_TURN_CHECK_EN, that check is omitted; turn still toggles on every applied move and all other checks remain.

Structure
- REQ-032: Package chess_pkg holds the following; board_state imports it:
  - square bit indices OCC_BIT=0, COLOR_BIT=1, KING_BIT=2;
  - COLOR_WHITE=0, COLOR_BLACK=1;
  - EMPTY_SQ=3'b000 and the four piece codes;
  - the FSM state enum.
- REQ-033: One combinational sub-module, move_checker, computes the REQ-017 error from the source code, destination code, coordinates, mover_color and turn.

Verification
- REQ-034: After reset: boardPos[6][0]=3'b001, [0][4]=3'b111, [3][3]=3'b000; turn=0; move_ready=1.
- REQ-035: Legal quiet move.
  - Stimulus: move (6,0)->(4,0), colour 0.
  - Response: move_done at N+3; [4][0]=3'b001, [6][0]=3'b000; captured=0; turn=1.
- REQ-036: Wrong turn.
  - Stimulus: from reset, move (1,0)->(3,0), colour 1.
  - With BOARD_TURN_CHECK_EN: move_err at N+2 and board unchanged.
  - Without BOARD_TURN_CHECK_EN: move_done at N+3.
- REQ-037: Illegal requests.
  - Stimulus: empty source (3,3)->(4,4), colour 0; then own-piece destination (7,1)->(6,1), colour 0.
  - Response: move_err for each; turn stays 0.
- REQ-038: King capture.
  - Stimulus: preload via legal moves so a white piece takes (0,4).
  - Response: captured=1 and king_captured=1; state OVER; move_ready=0; further move_valid is ignored; reset restores the initial image.
- REQ-039: Reset mid-move.
  - Stimulus: assert reset during the APPLY cycle of move (6,1)->(5,1).
  - Response: board equals the reset image, move_done never pulses, and turn=0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess board constants: square bit layout, colours, piece codes,
// FSM state encoding and the power-on board image.
package chess_pkg;

    localparam int OCC_BIT   = 0;
    localparam int COLOR_BIT = 1;
    localparam int KING_BIT  = 2;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam logic [2:0] EMPTY_SQ    = 3'b000;
    localparam logic [2:0] WHITE_PIECE = 3'b001;
    localparam logic [2:0] BLACK_PIECE = 3'b011;
    localparam logic [2:0] WHITE_KING  = 3'b101;
    localparam logic [2:0] BLACK_KING  = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        APPLY = 3'd2,
        RESP  = 3'd3,
        OVER  = 3'd4
    } state_e;

    // Black occupies rows 0-1 and white rows 6-7; kings sit on column 4.
    function automatic logic [2:0] init_square(input logic [2:0] row, input logic [2:0] col);
        logic [2:0] code;
        case (row)
            3'd0:    code = (col == 3'd4) ? BLACK_KING : BLACK_PIECE;
            3'd1:    code = BLACK_PIECE;
            3'd6:    code = WHITE_PIECE;
            3'd7:    code = (col == 3'd4) ? WHITE_KING : WHITE_PIECE;
            default: code = EMPTY_SQ;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/move_checker.sv
// Combinational legality screen for a requested move (ownership, turn, no-op).
// Macro BOARD_TURN_CHECK_EN enables the mover-colour-versus-turn check.
module move_checker
    import chess_pkg::*;
(
    input  logic [2:0] i_src_code,
    input  logic [2:0] i_dst_code,
    input  logic [2:0] i_from_row,
    input  logic [2:0] i_from_col,
    input  logic [2:0] i_to_row,
    input  logic [2:0] i_to_col,
    input  logic       i_mover_color,
    input  logic       i_turn,
    output logic       o_err
);

    logic w_src_empty;
    logic w_src_color_bad;
    logic w_turn_bad;
    logic w_same_sq;
    logic w_dst_own;

    assign w_src_empty     = ~i_src_code[OCC_BIT];
    assign w_src_color_bad = (i_src_code[COLOR_BIT] != i_mover_color);
    assign w_same_sq       = (i_from_row == i_to_row) && (i_from_col == i_to_col);
    assign w_dst_own       = i_dst_code[OCC_BIT] && (i_dst_code[COLOR_BIT] == i_mover_color);

`ifdef BOARD_TURN_CHECK_EN
    logic w_unused_bits;
    assign w_turn_bad    = (i_mover_color != i_turn);
    assign w_unused_bits = ^{i_src_code[KING_BIT], i_dst_code[KING_BIT]};
`else
    logic w_unused_bits;
    assign w_turn_bad    = 1'b0;
    assign w_unused_bits = ^{i_src_code[KING_BIT], i_dst_code[KING_BIT], i_turn};
`endif

    assign o_err = w_src_empty | w_src_color_bad | w_turn_bad | w_same_sq | w_dst_own;

endmodule

// File: rtl/board_state.sv
// Registered 8x8 board image with a move-request FSM (IDLE/CHECK/APPLY/RESP/OVER).
// Optional macro BOARD_TURN_CHECK_EN (in move_checker) rejects out-of-turn moves.
module board_state
    import chess_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_valid,
    output logic                   move_ready,
    input  logic [2:0]             from_row,
    input  logic [2:0]             from_col,
    input  logic [2:0]             to_row,
    input  logic [2:0]             to_col,
    input  logic                   mover_color,
    output logic [7:0][7:0][2:0]   boardPos,
    output logic                   move_done,
    output logic                   move_err,
    output logic                   captured,
    output logic                   king_captured,
    output logic                   turn
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [7:0][7:0][2:0] r_board;
    logic [2:0]           r_from_row;
    logic [2:0]           r_from_col;
    logic [2:0]           r_to_row;
    logic [2:0]           r_to_col;
    logic                 r_mover_color;
    logic                 r_move_ready;
    logic                 r_move_done;
    logic                 r_move_err;
    logic                 r_captured;
    logic                 r_king_captured;
    logic                 r_turn;

    logic                 w_accept;
    logic                 w_apply;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_check_err;
    logic [2:0]           w_src_code;
    logic [2:0]           w_dst_code;

    assign w_src_code = r_board[r_from_row][r_from_col];
    assign w_dst_code = r_board[r_to_row][r_to_col];

    move_checker u_move_checker (
        .i_src_code    (w_src_code),
        .i_dst_code    (w_dst_code),
        .i_from_row    (r_from_row),
        .i_from_col    (r_from_col),
        .i_to_row      (r_to_row),
        .i_to_col      (r_to_col),
        .i_mover_color (r_mover_color),
        .i_turn        (r_turn),
        .o_err         (w_check_err)
    );

    // Next-state and one-cycle response decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (move_valid && r_move_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CHECK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CHECK: begin
                if (w_check_err) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = APPLY;
                end
            end
            APPLY: begin
                w_apply     = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (r_king_captured) begin
                    w_state_nxt = OVER;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OVER:    w_state_nxt = OVER;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, request capture and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_move_ready    <= 1'b1;
            r_move_done     <= 1'b0;
            r_move_err      <= 1'b0;
            r_captured      <= 1'b0;
            r_king_captured <= 1'b0;
            r_turn          <= COLOR_WHITE;
            r_from_row      <= 3'd0;
            r_from_col      <= 3'd0;
            r_to_row        <= 3'd0;
            r_to_col        <= 3'd0;
            r_mover_color   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_move_ready <= (w_state_nxt == IDLE);
            r_move_done  <= w_done_nxt;
            r_move_err   <= w_err_nxt;
            if (w_accept) begin
                r_from_row    <= from_row;
                r_from_col    <= from_col;
                r_to_row      <= to_row;
                r_to_col      <= to_col;
                r_mover_color <= mover_color;
            end
            if (w_apply) begin
                r_captured <= w_dst_code[OCC_BIT];
                r_turn     <= ~r_turn;
                if (w_dst_code[KING_BIT]) begin
                    r_king_captured <= 1'b1;
                end
            end
        end
    end

    // Board storage; source and destination update on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_board[r][c] <= init_square(3'(r), 3'(c));
                end
            end
        end else if (w_apply) begin
            r_board[r_to_row][r_to_col]     <= w_src_code;
            r_board[r_from_row][r_from_col] <= EMPTY_SQ;
        end
    end

    assign move_ready    = r_move_ready;
    assign boardPos      = r_board;
    assign move_done     = r_move_done;
    assign move_err      = r_move_err;
    assign captured      = r_captured;
    assign king_captured = r_king_captured;
    assign turn          = r_turn;

endmodule

// File: tb/tb_board_state.sv
// Directed self-checking bench for board_state; honours BOARD_TURN_CHECK_EN.
module tb_board_state;

    logic                 clk;
    logic                 reset;
    logic                 move_valid;
    logic                 move_ready;
    logic [2:0]           from_row;
    logic [2:0]           from_col;
    logic [2:0]           to_row;
    logic [2:0]           to_col;
    logic                 mover_color;
    logic [7:0][7:0][2:0] boardPos;
    logic                 move_done;
    logic                 move_err;
    logic                 captured;
    logic                 king_captured;
    logic                 turn;

    int n_checks = 0;
    int n_fail   = 0;
    int done_at;
    int err_at;
    int pulses;

    board_state dut (
        .clk           (clk),
        .reset         (reset),
        .move_valid    (move_valid),
        .move_ready    (move_ready),
        .from_row      (from_row),
        .from_col      (from_col),
        .to_row        (to_row),
        .to_col        (to_col),
        .mover_color   (mover_color),
        .boardPos      (boardPos),
        .move_done     (move_done),
        .move_err      (move_err),
        .captured      (captured),
        .king_captured (king_captured),
        .turn          (turn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_init(input int r, input int c);
        if (r <= 1) return (r == 0 && c == 4) ? 3'b111 : 3'b011;
        else if (r >= 6) return (r == 7 && c == 4) ? 3'b101 : 3'b001;
        else return 3'b000;
    endfunction

    function automatic int board_mismatches();
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (boardPos[r][c] !== exp_init(r, c)) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; k counts cycles after the acceptance cycle N.
    task automatic do_move(input logic [2:0] fr, input logic [2:0] fc, input logic [2:0] tr,
                           input logic [2:0] tc, input logic col,
                           output int d_at, output int e_at, output int np);
        d_at = 0;
        e_at = 0;
        np   = 0;
        from_row = fr; from_col = fc; to_row = tr; to_col = tc; mover_color = col;
        move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (move_done && d_at == 0) d_at = k;
            if (move_err && e_at == 0) e_at = k;
            np += int'(move_done) + int'(move_err);
        end
    endtask

    initial begin
        reset = 1'b1; move_valid = 1'b0;
        from_row = 3'd0; from_col = 3'd0; to_row = 3'd0; to_col = 3'd0; mover_color = 1'b0;
        #2;
        chk("in_reset_done", move_done, 1'b0);
        chk("in_reset_turn", turn, 1'b0);
        do_reset();

        chk("rst_sq60", boardPos[6][0], 3'b001);
        chk("rst_sq04", boardPos[0][4], 3'b111);
        chk("rst_sq33", boardPos[3][3], 3'b000);
        chk("rst_sq74", boardPos[7][4], 3'b101);
        chk("rst_board", board_mismatches(), 0);
        chk("rst_turn", turn, 1'b0);
        chk("rst_ready", move_ready, 1'b1);
        chk("rst_flags", {captured, king_captured, move_done, move_err}, 4'b0000);

        // Legal quiet move
        do_move(3'd6, 3'd0, 3'd4, 3'd0, 1'b0, done_at, err_at, pulses);
        chk("quiet_done_at", done_at, 3);
        chk("quiet_err_at", err_at, 0);
        chk("quiet_pulses", pulses, 1);
        chk("quiet_dst", boardPos[4][0], 3'b001);
        chk("quiet_src", boardPos[6][0], 3'b000);
        chk("quiet_captured", captured, 1'b0);
        chk("quiet_turn", turn, 1'b1);
        chk("quiet_ready", move_ready, 1'b1);

        // Wrong turn from reset
        do_reset();
        do_move(3'd1, 3'd0, 3'd3, 3'd0, 1'b1, done_at, err_at, pulses);
`ifdef BOARD_TURN_CHECK_EN
        chk("wturn_err_at", err_at, 2);
        chk("wturn_done_at", done_at, 0);
        chk("wturn_board", board_mismatches(), 0);
        chk("wturn_turn", turn, 1'b0);
`else
        chk("wturn_done_at", done_at, 3);
        chk("wturn_err_at", err_at, 0);
        chk("wturn_dst", boardPos[3][0], 3'b011);
        chk("wturn_turn", turn, 1'b1);
`endif
        chk("wturn_pulses", pulses, 1);

        // Illegal requests
        do_reset();
        do_move(3'd3, 3'd3, 3'd4, 3'd4, 1'b0, done_at, err_at, pulses);
        chk("empty_err_at", err_at, 2);
        chk("empty_pulses", pulses, 1);
        do_move(3'd7, 3'd1, 3'd6, 3'd1, 1'b0, done_at, err_at, pulses);
        chk("own_dst_err_at", err_at, 2);
        chk("own_dst_done_at", done_at, 0);
        do_move(3'd6, 3'd2, 3'd6, 3'd2, 1'b0, done_at, err_at, pulses);
        chk("same_sq_err_at", err_at, 2);
        do_move(3'd1, 3'd1, 3'd2, 3'd1, 1'b0, done_at, err_at, pulses);
        chk("src_color_err_at", err_at, 2);
        chk("illegal_turn", turn, 1'b0);
        chk("illegal_board", board_mismatches(), 0);

        // Capture bookkeeping, then king capture
        do_reset();
        do_move(3'd6, 3'd0, 3'd1, 3'd0, 1'b0, done_at, err_at, pulses);
        chk("cap_done_at", done_at, 3);
        chk("cap_captured", captured, 1'b1);
        chk("cap_king", king_captured, 1'b0);
        chk("cap_dst", boardPos[1][0], 3'b001);
        do_move(3'd3, 3'd3, 3'd4, 3'd4, 1'b1, done_at, err_at, pulses);
        chk("cap_hold_err_at", err_at, 2);
        chk("cap_hold", captured, 1'b1);
        do_move(3'd1, 3'd1, 3'd2, 3'd1, 1'b1, done_at, err_at, pulses);
        chk("cap_clear_done_at", done_at, 3);
        chk("cap_clear", captured, 1'b0);
        chk("cap_turn", turn, 1'b0);
        do_move(3'd6, 3'd4, 3'd0, 3'd4, 1'b0, done_at, err_at, pulses);
        chk("king_done_at", done_at, 3);
        chk("king_captured", captured, 1'b1);
        chk("king_flag", king_captured, 1'b1);
        chk("king_dst", boardPos[0][4], 3'b001);
        chk("king_src", boardPos[6][4], 3'b000);
        chk("over_ready", move_ready, 1'b0);

        from_row = 3'd6; from_col = 3'd5; to_row = 3'd5; to_col = 3'd5; mover_color = 1'b1;
        move_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pulses += int'(move_done) + int'(move_err) + int'(move_ready);
        end
        move_valid = 1'b0;
        chk("over_ignored", pulses, 0);
        chk("over_frozen_dst", boardPos[5][5], 3'b000);
        chk("over_frozen_src", boardPos[6][5], 3'b001);
        chk("over_king_sticky", king_captured, 1'b1);

        do_reset();
        chk("after_over_board", board_mismatches(), 0);
        chk("after_over_flags", {captured, king_captured, turn}, 3'b000);
        chk("after_over_ready", move_ready, 1'b1);

        // Reset asserted during the APPLY cycle
        from_row = 3'd6; from_col = 3'd1; to_row = 3'd5; to_col = 3'd1; mover_color = 1'b0;
        move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(negedge clk);
        chk("mid_check_done", move_done, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_done", move_done, 1'b0);
        chk("mid_rst_board", board_mismatches(), 0);
        chk("mid_rst_turn", turn, 1'b0);
        pulses = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pulses += int'(move_done) + int'(move_err);
        end
        chk("mid_no_done", pulses, 0);
        chk("mid_board", board_mismatches(), 0);
        chk("mid_turn", turn, 1'b0);
        chk("mid_ready", move_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
